// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the main-memory port arbiter.
package mem_arb_pkg;

    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_ADDR_W     = 32;
    localparam int DEFAULT_DEPTH_LOG2 = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (fetch/data) and memory-side signals of the arbiter.
// The arbiter uses the slave modport; requesters plus memory form the master side.
interface mem_port_arbiter_if #(
    parameter int DATA_W     = mem_arb_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W     = mem_arb_pkg::DEFAULT_ADDR_W,
    parameter int DEPTH_LOG2 = mem_arb_pkg::DEFAULT_DEPTH_LOG2
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_gnt;
    logic                  i_valid;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_valid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  m_en;
    logic                  m_we;
    logic [DEPTH_LOG2-1:0] m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W-1:0]     m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        output m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick2.sv
// Two-way conflict selector. Build option MEM_ARB_RR_EN selects round-robin;
// otherwise the data requester always wins a conflict.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  req_t last_gnt,
    output logic gnt_i,
    output logic gnt_d
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (req_i && req_d) begin
            // Favour whoever did not win last time
            if (last_gnt == REQ_I) begin
                gnt_d = 1'b1;
            end else begin
                gnt_i = 1'b1;
            end
        end else begin
            gnt_i = req_i;
            gnt_d = req_d;
        end
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (req_i && req_d) begin
            gnt_d = 1'b1;
        end else begin
            gnt_i = req_i;
            gnt_d = req_d;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between fetch (I) and load/store (D);
// conflict policy lives in arb_pick2 (MEM_ARB_RR_EN selects round-robin).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic               clk,
    input  logic               Reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int NUM_REQ = 2;

    owner_t owner_reg;
    owner_t owner_next;
    req_t   last_gnt_reg;
    req_t   last_gnt_next;

    logic pick_i;
    logic pick_d;
    logic gnt_i;
    logic gnt_d;

    logic [NUM_REQ-1:0] valid_vec;
    owner_t             own_code [NUM_REQ];

    arb_pick2 u_pick (
        .req_i    (bus.i_req),
        .req_d    (bus.d_req),
        .last_gnt (last_gnt_reg),
        .gnt_i    (pick_i),
        .gnt_d    (pick_d)
    );

    // Reset blocks any new issue combinationally
    always_comb begin
        gnt_i = pick_i & ~Reset;
        gnt_d = pick_d & ~Reset;
    end

    assign bus.i_gnt   = gnt_i;
    assign bus.d_gnt   = gnt_d;
    assign bus.m_en    = gnt_i | gnt_d;
    assign bus.m_we    = gnt_d & bus.d_we;
    assign bus.m_wdata = Reset ? '0 : bus.d_wdata;

    always_comb begin
        bus.m_addr = '0;
        if (gnt_d) begin
            bus.m_addr = bus.d_addr[DEPTH_LOG2+1:2];
        end else if (gnt_i) begin
            bus.m_addr = bus.i_addr[DEPTH_LOG2+1:2];
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[ADDR_W-1:DEPTH_LOG2+2], bus.i_addr[1:0],
                                bus.d_addr[ADDR_W-1:DEPTH_LOG2+2], bus.d_addr[1:0]};

    always_comb begin
        owner_next    = OWN_NONE;
        last_gnt_next = last_gnt_reg;
        if (gnt_d) begin
            owner_next    = OWN_D;
            last_gnt_next = REQ_D;
        end else if (gnt_i) begin
            owner_next    = OWN_I;
            last_gnt_next = REQ_I;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            owner_reg    <= OWN_NONE;
            last_gnt_reg <= REQ_I;
        end else begin
            owner_reg    <= owner_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    assign own_code[0] = OWN_I;
    assign own_code[1] = OWN_D;

    // Valid is masked during Reset so an access issued just before it is never reported
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_valid
            assign valid_vec[gi] = (owner_reg == own_code[gi]) & ~Reset;
        end
    endgenerate

    assign bus.i_valid = valid_vec[0];
    assign bus.d_valid = valid_vec[1];
    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-before-write memory model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic Reset;
    int   total;
    int   bad;

    logic [31:0] mem [256];
    bit          prev_d;
    bit          exp_d;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.m_en) begin
            bus.m_rdata <= mem[bus.m_addr];
            if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 256; k++) mem[k] = 32'hC0DE_0000 | k;
        bus.m_rdata = '0;
        Reset       = 1'b1;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h14;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h18;
        bus.d_wdata = 32'hDEAD_BEEF;

        // Reset held with both requests high
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("rst_i_gnt", bus.i_gnt, 0);
            chk("rst_d_gnt", bus.d_gnt, 0);
            chk("rst_m_en", bus.m_en, 0);
            chk("rst_m_we", bus.m_we, 0);
            $display("reset cycle %0d: i_gnt=%0b d_gnt=%0b m_en=%0b", k, bus.i_gnt, bus.d_gnt, bus.m_en);
        end

        @(negedge clk);
        Reset = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0; #1;
        chk("rel_i_valid", bus.i_valid, 0);
        chk("rel_d_valid", bus.d_valid, 0);
        chk("rel_m_en", bus.m_en, 0);
        $display("release: i_valid=%0b d_valid=%0b", bus.i_valid, bus.d_valid);

        // Both requests held four cycles: RR alternates from D, fixed picks D always
        bus.i_req = 1'b1; bus.i_addr = 32'h14;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h18;
        prev_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            else begin @(negedge clk); end
            #1;
            exp_d = RR ? (k % 2 == 0) : 1'b1;
            chk("conf_d_gnt", bus.d_gnt, exp_d);
            chk("conf_i_gnt", bus.i_gnt, !exp_d);
            chk("conf_m_addr", bus.m_addr, exp_d ? 32'h6 : 32'h5);
            if (k > 0) chk("conf_d_valid", bus.d_valid, prev_d);
            $display("conflict %0d: i_gnt=%0b d_gnt=%0b m_addr=%h", k, bus.i_gnt, bus.d_gnt, bus.m_addr);
            prev_d = exp_d;
        end
        @(negedge clk);
        bus.i_req = 1'b0; bus.d_req = 1'b0; #1;
        chk("conf_last_d_valid", bus.d_valid, prev_d);
        chk("conf_last_i_valid", bus.i_valid, !prev_d);
        chk("conf_last_rdata", bus.d_rdata, prev_d ? 32'hC0DE_0006 : 32'hC0DE_0005);
        $display("conflict tail: d_valid=%0b rdata=%h", bus.d_valid, bus.d_rdata);

        // Single fetch, address 0x14 -> word 5
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h14; #1;
        chk("fetch_i_gnt", bus.i_gnt, 1);
        chk("fetch_m_addr", bus.m_addr, 32'h5);
        chk("fetch_m_we", bus.m_we, 0);
        $display("fetch issue: i_gnt=%0b m_addr=%h", bus.i_gnt, bus.m_addr);
        // Upper bits wrap: 0xFFFFFC14 also maps to word 5
        @(negedge clk);
        bus.i_addr = 32'hFFFF_FC14; #1;
        chk("fetch_i_valid", bus.i_valid, 1);
        chk("fetch_i_rdata", bus.i_rdata, 32'hC0DE_0005);
        chk("wrap_m_addr", bus.m_addr, 32'h5);
        $display("fetch data: i_valid=%0b i_rdata=%h wrap m_addr=%h", bus.i_valid, bus.i_rdata, bus.m_addr);

        // Store then load to the same word
        @(negedge clk);
        bus.i_req = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h4594_C818; bus.d_wdata = 32'h4D2A_6899; #1;
        chk("st_d_gnt", bus.d_gnt, 1);
        chk("st_m_we", bus.m_we, 1);
        chk("st_m_addr", bus.m_addr, 32'h06);
        chk("st_m_wdata", bus.m_wdata, 32'h4D2A_6899);
        chk("st_i_valid", bus.i_valid, 1);
        $display("store issue: d_gnt=%0b m_we=%0b m_addr=%h", bus.d_gnt, bus.m_we, bus.m_addr);
        @(negedge clk);
        bus.d_we = 1'b0; #1;
        chk("ld_d_gnt", bus.d_gnt, 1);
        chk("ld_m_we", bus.m_we, 0);
        chk("st_ack_valid", bus.d_valid, 1);
        chk("st_ack_old", bus.d_rdata, 32'hC0DE_0006);
        $display("load issue: d_gnt=%0b store ack d_valid=%0b old=%h", bus.d_gnt, bus.d_valid, bus.d_rdata);
        @(negedge clk);
        bus.d_req = 1'b0; #1;
        chk("ld_valid", bus.d_valid, 1);
        chk("ld_rdata", bus.d_rdata, 32'h4D2A_6899);
        chk("ld_d_gnt_off", bus.d_gnt, 0);
        $display("load data: d_valid=%0b d_rdata=%h", bus.d_valid, bus.d_rdata);

        // Dropped data request: only the fetch issues
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h14;
        bus.d_req = 1'b0; bus.d_we = 1'b1; bus.d_addr = 32'h80; #1;
        chk("drop_i_gnt", bus.i_gnt, 1);
        chk("drop_d_gnt", bus.d_gnt, 0);
        chk("drop_m_we", bus.m_we, 0);
        $display("drop: i_gnt=%0b d_gnt=%0b m_we=%0b", bus.i_gnt, bus.d_gnt, bus.m_we);
        @(negedge clk);
        bus.i_req = 1'b0; #1;
        chk("drop_d_valid", bus.d_valid, 0);
        chk("drop_i_valid", bus.i_valid, 1);
        $display("drop resp: i_valid=%0b d_valid=%0b", bus.i_valid, bus.d_valid);

        // Store granted in N, Reset in N+1
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678; #1;
        chk("rm_d_gnt", bus.d_gnt, 1);
        $display("cycle N: d_gnt=%0b m_addr=%h", bus.d_gnt, bus.m_addr);
        @(negedge clk);
        Reset = 1'b1; bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0; #1;
        chk("rm_n1_d_valid", bus.d_valid, 0);
        chk("rm_n1_i_valid", bus.i_valid, 0);
        chk("rm_n1_m_en", bus.m_en, 0);
        chk("rm_n1_m_addr", bus.m_addr, 0);
        $display("cycle N+1: d_valid=%0b m_en=%0b", bus.d_valid, bus.m_en);
        @(negedge clk);
        Reset = 1'b0; #1;
        chk("rm_n2_d_valid", bus.d_valid, 0);
        chk("rm_n2_i_valid", bus.i_valid, 0);
        chk("rm_first_conf_d", bus.d_gnt, 1);
        chk("rm_first_conf_addr", bus.m_addr, 32'h10);
        $display("cycle N+2: d_valid=%0b d_gnt=%0b m_addr=%h", bus.d_valid, bus.d_gnt, bus.m_addr);
        @(negedge clk);
        bus.i_req = 1'b0; bus.d_req = 1'b0; #1;
        chk("rm_ld_valid", bus.d_valid, 1);
        chk("rm_ld_rdata", bus.d_rdata, 32'h1234_5678);
        $display("post-reset load: d_valid=%0b d_rdata=%h", bus.d_valid, bus.d_rdata);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
